multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle opcode decoder.
- An FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback, emitting per-cycle datapath controls.
- Memory states wait on a memory-ready handshake, so variable-latency memory is supported.
- Adds optional bne support, illegal-opcode detection and a retired-instruction counter. Sits between the instruction register and the multicycle datapath.

---
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory-ready stalls, illegal-opcode flag and retire count.
module multicycle_control #(
    parameter int CNT_W       = 32,
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             branch_ne,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdest,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             op_legal;
    logic             retire;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW,
            OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_BNE:                op_legal = SUPPORT_BNE;
            default:               op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (op_legal) begin
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_BNE:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // A store retires only once its memory access completes.
    always_comb begin
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR:          retire = mem_ready;
            default:          retire = 1'b0;
        endcase
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Controls are held low for the whole reset window, FETCH included.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        branch_ne   = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsrc       = 2'b00;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal = ~op_legal;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdest  = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b01;
                    pcsrc       = 2'b01;
                    pcwritecond = 1'b1;
                    branch_ne   = (opcode == OP_BNE);
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: default build (A) and a CNT_W=4,
// no-bne build (B); the idle one is parked in reset.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdest;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        int cyc;
        int ret;
        int ill;
        int rw;
        int mw;
        int pwc;
        int mtr;
        int pw;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [5:0] opcode;
    logic       mem_ready;
    int         sel;

    logic a_pcwrite, a_pcwritecond, a_branch_ne, a_iord, a_memread;
    logic a_memwrite, a_irwrite, a_memtoreg, a_regdest, a_regwrite;
    logic a_alusrca, a_illegal;
    logic [1:0] a_alusrcb, a_aluop, a_pcsrc;
    logic [31:0] a_instret;
    logic [3:0] a_state;

    logic b_pcwrite, b_pcwritecond, b_branch_ne, b_iord, b_memread;
    logic b_memwrite, b_irwrite, b_memtoreg, b_regdest, b_regwrite;
    logic b_alusrca, b_illegal;
    logic [1:0] b_alusrcb, b_aluop, b_pcsrc;
    logic [3:0] b_instret;
    logic [3:0] b_state;

    multicycle_control #(.CNT_W(32), .SUPPORT_BNE(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(a_pcwrite), .pcwritecond(a_pcwritecond),
        .branch_ne(a_branch_ne), .iord(a_iord), .memread(a_memread),
        .memwrite(a_memwrite), .irwrite(a_irwrite), .memtoreg(a_memtoreg),
        .regdest(a_regdest), .regwrite(a_regwrite), .alusrca(a_alusrca),
        .alusrcb(a_alusrcb), .aluop(a_aluop), .pcsrc(a_pcsrc),
        .illegal(a_illegal), .instret(a_instret), .state(a_state)
    );

    multicycle_control #(.CNT_W(4), .SUPPORT_BNE(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond),
        .branch_ne(b_branch_ne), .iord(b_iord), .memread(b_memread),
        .memwrite(b_memwrite), .irwrite(b_irwrite), .memtoreg(b_memtoreg),
        .regdest(b_regdest), .regwrite(b_regwrite), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .aluop(b_aluop), .pcsrc(b_pcsrc),
        .illegal(b_illegal), .instret(b_instret), .state(b_state)
    );

    ctrl_t       v;
    logic [3:0]  v_state;
    logic [31:0] v_instret;

    always_comb begin
        if (sel == 0) begin
            v = {a_pcwrite, a_pcwritecond, a_branch_ne, a_iord, a_memread,
                 a_memwrite, a_irwrite, a_memtoreg, a_regdest, a_regwrite,
                 a_alusrca, a_alusrcb, a_aluop, a_pcsrc, a_illegal};
            v_state   = a_state;
            v_instret = a_instret;
        end else begin
            v = {b_pcwrite, b_pcwritecond, b_branch_ne, b_iord, b_memread,
                 b_memwrite, b_irwrite, b_memtoreg, b_regdest, b_regwrite,
                 b_alusrca, b_alusrcb, b_aluop, b_pcsrc, b_illegal};
            v_state   = b_state;
            v_instret = {28'd0, b_instret};
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel       = s;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;
        tick();
        check("rst_ctrl", 32'(v), 32'd0);
        check("rst_state", 32'(v_state), 32'd0);
        check("rst_instret", v_instret, 32'd0);
        if (s == 0) rst_a = 1'b0;
        else rst_b = 1'b0;
    endtask

    // One instruction with mem_ready held high, tallying control pulses.
    task automatic run_instr(input logic [5:0] op, output int cyc,
                             output int ill, output int rw, output int mw,
                             output int pwc, output int mtr, output int pw,
                             output int ret);
        logic [31:0] i0;
        i0  = v_instret;
        cyc = 0; ill = 0; rw = 0; mw = 0; pwc = 0; mtr = 0; pw = 0;
        do begin
            opcode    = op;
            mem_ready = 1'b1;
            #1;
            ill += int'(v.illegal);
            rw  += int'(v.regwrite);
            mw  += int'(v.memwrite);
            pwc += int'(v.pcwritecond);
            mtr += int'(v.memtoreg);
            pw  += int'(v.pcwrite);
            @(posedge clk);
            #1;
            cyc++;
        end while (v_state != 4'd0 && cyc < 50);
        ret = int'((v_instret - i0) & ((sel == 0) ? 32'hFFFF_FFFF : 32'hF));
    endtask

    // Reference plan: phase count, which phases stall on mem_ready, effects.
    function automatic int plan(input logic [5:0] op, output logic [7:0] wm,
                                output bit ret, output bit wr,
                                output bit mwr, output bit ill);
        ret = 1'b1; wr = 1'b0; mwr = 1'b0; ill = 1'b0; wm = 8'b0000_0001;
        case (op)
            OP_R, OP_ADDI: begin wr = 1'b1; return 4; end
            OP_LW: begin wr = 1'b1; wm = 8'b0000_1001; return 5; end
            OP_SW: begin mwr = 1'b1; wm = 8'b0000_1001; return 4; end
            OP_BEQ, OP_BNE, OP_J: return 3;
            default: begin ret = 1'b0; ill = 1'b1; return 2; end
        endcase
    endfunction

    vec_t tbl[10];
    logic [5:0] pool[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, ill, rw, mw, pwc, mtr, pw, ret;
        int rt_seq[4];
        int lw_rdy[10], lw_st[10], lw_irw[10];
        vec_t e;
        logic [31:0] model_cnt;

        tbl[0] = '{OP_R,    4, 1, 0, 1, 0, 0, 0, 1};
        tbl[1] = '{OP_LW,   5, 1, 0, 1, 0, 0, 1, 1};
        tbl[2] = '{OP_SW,   4, 1, 0, 0, 1, 0, 0, 1};
        tbl[3] = '{OP_BEQ,  3, 1, 0, 0, 0, 1, 0, 1};
        tbl[4] = '{OP_BNE,  3, 1, 0, 0, 0, 1, 0, 1};
        tbl[5] = '{OP_ADDI, 4, 1, 0, 1, 0, 0, 0, 1};
        tbl[6] = '{OP_J,    3, 1, 0, 0, 0, 0, 0, 2};
        tbl[7] = '{6'b111111, 2, 0, 1, 0, 0, 0, 0, 1};
        tbl[8] = '{6'b000011, 2, 0, 1, 0, 0, 0, 0, 1};
        tbl[9] = '{6'b001101, 2, 0, 1, 0, 0, 0, 0, 1};
        pool = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};
        rt_seq = '{0, 1, 6, 7};
        lw_rdy = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
        lw_st  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
        lw_irw = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

        sel = 0; rst_a = 1'b1; rst_b = 1'b1; opcode = OP_R; mem_ready = 1'b0;
        do_reset(0);

        for (int i = 0; i < 4; i++) begin
            opcode = OP_R; mem_ready = 1'b1; #1;
            check($sformatf("rtype_state[%0d]", i), 32'(v_state), 32'(rt_seq[i]));
            check($sformatf("rtype_regwrite[%0d]", i), 32'(v.regwrite), 32'(rt_seq[i] == 7));
            check($sformatf("rtype_regdest[%0d]", i), 32'(v.regdest), 32'(rt_seq[i] == 7));
            tick();
        end
        check("rtype_end_state", 32'(v_state), 32'd0);
        check("rtype_instret", v_instret, 32'd1);

        for (int i = 0; i < 10; i++) begin
            opcode = OP_LW; mem_ready = lw_rdy[i][0]; #1;
            check($sformatf("lw_state[%0d]", i), 32'(v_state), 32'(lw_st[i]));
            check($sformatf("lw_irwrite[%0d]", i), 32'(v.irwrite), 32'(lw_irw[i]));
            check($sformatf("lw_memtoreg[%0d]", i), 32'(v.memtoreg), 32'(i == 9));
            tick();
        end
        check("lw_end_state", 32'(v_state), 32'd0);
        check("lw_instret", v_instret, 32'd2);

        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 3; c++) begin
                opcode = (b == 1) ? OP_BNE : OP_BEQ; mem_ready = 1'b1; #1;
                if (c == 2) begin
                    check($sformatf("br%0d_state", b), 32'(v_state), 32'd8);
                    check($sformatf("br%0d_pwc", b), 32'(v.pcwritecond), 32'd1);
                    check($sformatf("br%0d_pcsrc", b), 32'(v.pcsrc), 32'd1);
                    check($sformatf("br%0d_aluop", b), 32'(v.aluop), 32'd1);
                    check($sformatf("br%0d_ne", b), 32'(v.branch_ne), 32'(b));
                end
                tick();
            end
            check($sformatf("br%0d_end_state", b), 32'(v_state), 32'd0);
        end
        check("br_instret", v_instret, 32'd4);

        for (int s = 0; s < 2; s++) begin
            do_reset(s);
            for (int i = 0; i < 10; i++) begin
                e = tbl[i];
                if (s == 1 && e.op == OP_BNE) e = '{OP_BNE, 2, 0, 1, 0, 0, 0, 0, 1};
                run_instr(e.op, cyc, ill, rw, mw, pwc, mtr, pw, ret);
                check($sformatf("tbl%0d[%0d].cycles", s, i), 32'(cyc), 32'(e.cyc));
                check($sformatf("tbl%0d[%0d].retire", s, i), 32'(ret), 32'(e.ret));
                check($sformatf("tbl%0d[%0d].illegal", s, i), 32'(ill), 32'(e.ill));
                check($sformatf("tbl%0d[%0d].regwrite", s, i), 32'(rw), 32'(e.rw));
                check($sformatf("tbl%0d[%0d].memwrite", s, i), 32'(mw), 32'(e.mw));
                check($sformatf("tbl%0d[%0d].pcwcond", s, i), 32'(pwc), 32'(e.pwc));
                check($sformatf("tbl%0d[%0d].memtoreg", s, i), 32'(mtr), 32'(e.mtr));
                check($sformatf("tbl%0d[%0d].pcwrite", s, i), 32'(pw), 32'(e.pw));
            end
        end

        do_reset(0);
        model_cnt = 32'd0;
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            logic [7:0] wm;
            bit r, wr, mwr, il, adv;
            int np, ph, guard;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : pool[$urandom_range(0, 7)];
            np = plan(op, wm, r, wr, mwr, il);
            ph = 0; guard = 0;
            while (ph < np) begin
                opcode = op; mem_ready = 1'($urandom_range(0, 1)); #1;
                check("rnd_fetch", 32'(v_state == 4'd0), 32'(ph == 0));
                check("rnd_instret", v_instret, model_cnt);
                check("rnd_illegal", 32'(v.illegal), 32'(il && ph == 1));
                check("rnd_regwrite", 32'(v.regwrite), 32'(wr && ph == np - 1));
                check("rnd_memwrite", 32'(v.memwrite), 32'(mwr && ph == np - 1));
                adv = !wm[ph] || mem_ready;
                tick();
                if (adv) ph++;
                guard++;
                if (guard > 400) begin
                    check("rnd_timeout", 32'(guard), 32'd0);
                    break;
                end
            end
            if (r) model_cnt = model_cnt + 32'd1;
        end
        check("rnd_final_instret", v_instret, model_cnt);

        for (int c = 0; c < 3; c++) begin
            opcode = OP_SW; mem_ready = 1'b1; tick();
        end
        opcode = OP_SW; mem_ready = 1'b0; #1;
        check("mwr_state", 32'(v_state), 32'd5);
        check("mwr_memwrite", 32'(v.memwrite), 32'd1);
        tick();
        #2;
        rst_a = 1'b1;
        #1;
        check("mwr_rst_ctrl", 32'(v), 32'd0);
        check("mwr_rst_state", 32'(v_state), 32'd0);
        check("mwr_rst_instret", v_instret, 32'd0);
        tick();
        rst_a = 1'b0; mem_ready = 1'b1; #1;
        check("mwr_post_state", 32'(v_state), 32'd0);
        check("mwr_post_instret", v_instret, 32'd0);
        tick();
        run_instr(OP_R, cyc, ill, rw, mw, pwc, mtr, pw, ret);
        check("mwr_after_r_instret", v_instret, 32'd1);

        do_reset(1);
        for (int k = 1; k <= 17; k++) begin
            for (int c = 0; c < 3; c++) begin
                opcode = OP_J; mem_ready = 1'b1; #1;
                if (c == 2) begin
                    check($sformatf("wrap%0d_state", k), 32'(v_state), 32'd11);
                    check($sformatf("wrap%0d_pcwrite", k), 32'(v.pcwrite), 32'd1);
                    check($sformatf("wrap%0d_pcsrc", k), 32'(v.pcsrc), 32'd2);
                end
                tick();
            end
            check($sformatf("wrap%0d_instret", k), v_instret, 32'(k % 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
